// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bit positions and FSM states.
// Also provides the signed-overflow helper used by the add/subtract paths.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_ADDU  = 4'h1,
        OP_ADDC  = 4'h2,
        OP_ADDCU = 4'h3,
        OP_SUB   = 4'h4,
        OP_CMP   = 4'h5,
        OP_CMPU  = 4'h6,
        OP_AND   = 4'h7,
        OP_OR    = 4'h8,
        OP_XOR   = 4'h9,
        OP_NOT   = 4'hA,
        OP_LSH   = 4'hB,
        OP_RSH   = 4'hC,
        OP_ARSH  = 4'hD,
        OP_MUL   = 4'hE,
        OP_RSVD  = 4'hF
    } alu_op_t;

    localparam int NUM_FLAGS = 5;
    localparam int FLAG_N    = 0;
    localparam int FLAG_L    = 1;
    localparam int FLAG_F    = 2;
    localparam int FLAG_C    = 3;
    localparam int FLAG_Z    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_t;

    // Two's-complement overflow from the sign bits of the addends and the sum.
    // For subtraction pass the inverted sign of the subtrahend.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH partial products total.
// The first partial product is folded into the load so done rises WIDTH-1 cycles after start.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      cnt_reg;
    logic               run_reg;
    logic               done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            run_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                acc_reg    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                mcand_reg  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                mplier_reg <= b >> 1;
                cnt_reg    <= CW'(WIDTH - 1);
                run_reg    <= 1'b1;
            end else if (run_reg) begin
                if (mplier_reg[0]) begin
                    acc_reg <= acc_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg - CW'(1);
                // Last partial product lands on this edge.
                if (cnt_reg == CW'(1)) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done    = done_reg;
    assign product = acc_reg;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes; single-cycle ops complete in one cycle,
// MUL iterates in alu_mul_iter. Results and flags are held until the consumer takes them.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      result,
    output logic [NUM_FLAGS-1:0]  flags
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH[WIDTH-1:0];

    alu_state_t            state_reg;
    logic [WIDTH-1:0]      result_reg;
    logic [NUM_FLAGS-1:0]  flags_reg;
    logic                  carry_reg;
    logic                  out_valid_reg;
    logic                  ready_en_reg;

    alu_op_t               op_t;
    logic                  accept;
    logic                  is_mul;

    logic [WIDTH:0]        add_ext;
    logic [WIDTH:0]        addc_ext;
    logic [WIDTH-1:0]      sub_res;
    logic                  shift_big;

    logic [WIDTH-1:0]      res_comb;
    logic [NUM_FLAGS-1:0]  flg_comb;
    logic                  carry_we;
    logic                  z_en;

    logic                  mul_done;
    logic [2*WIDTH-1:0]    mul_product;
    logic [NUM_FLAGS-1:0]  mul_flags;

    assign op_t   = alu_op_t'(op);
    assign is_mul = (MUL_EN != 0) && (op_t == OP_MUL);

    // ready_en_reg keeps in_ready low through reset and until the first edge after release.
    assign in_ready = ready_en_reg &&
                      ((state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && out_ready));
    assign accept   = in_valid && in_ready;

    assign add_ext   = {1'b0, a} + {1'b0, b};
    assign addc_ext  = add_ext + {{WIDTH{1'b0}}, carry_reg};
    assign sub_res   = a - b;
    assign shift_big = (b >= WIDTH_VAL);

    always_comb begin
        res_comb = '0;
        flg_comb = '0;
        carry_we = 1'b0;
        z_en     = 1'b0;
        case (op_t)
            OP_ADD: begin
                res_comb         = add_ext[MSB:0];
                flg_comb[FLAG_F] = signed_ovf(a[MSB], b[MSB], add_ext[MSB]);
                z_en             = 1'b1;
            end
            OP_ADDU: begin
                res_comb         = add_ext[MSB:0];
                flg_comb[FLAG_C] = add_ext[WIDTH];
                carry_we         = 1'b1;
                z_en             = 1'b1;
            end
            OP_ADDC: begin
                res_comb         = addc_ext[MSB:0];
                flg_comb[FLAG_F] = signed_ovf(a[MSB], b[MSB], addc_ext[MSB]);
                z_en             = 1'b1;
            end
            OP_ADDCU: begin
                res_comb         = addc_ext[MSB:0];
                flg_comb[FLAG_C] = addc_ext[WIDTH];
                carry_we         = 1'b1;
                z_en             = 1'b1;
            end
            OP_SUB: begin
                res_comb         = sub_res;
                flg_comb[FLAG_F] = signed_ovf(a[MSB], ~b[MSB], sub_res[MSB]);
                z_en             = 1'b1;
            end
            OP_CMP: begin
                flg_comb[FLAG_N] = ($signed(a) < $signed(b));
                flg_comb[FLAG_L] = ($signed(a) < $signed(b));
                flg_comb[FLAG_Z] = (a == b);
            end
            OP_CMPU: begin
                flg_comb[FLAG_N] = (a < b);
                flg_comb[FLAG_L] = (a < b);
                flg_comb[FLAG_Z] = (a == b);
            end
            OP_AND: begin
                res_comb = a & b;
                z_en     = 1'b1;
            end
            OP_OR: begin
                res_comb = a | b;
                z_en     = 1'b1;
            end
            OP_XOR: begin
                res_comb = a ^ b;
                z_en     = 1'b1;
            end
            OP_NOT: begin
                res_comb = ~a;
                z_en     = 1'b1;
            end
            OP_LSH:  res_comb = shift_big ? '0 : (a << b);
            OP_RSH:  res_comb = shift_big ? '0 : (a >> b);
            OP_ARSH: res_comb = shift_big ? {WIDTH{a[MSB]}} : WIDTH'($signed(a) >>> b);
            // MUL is handled by the iterative unit; illegal ops yield zero.
            default: ;
        endcase
        if (z_en && (res_comb == '0)) begin
            flg_comb[FLAG_Z] = 1'b1;
        end
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_iter #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (accept && is_mul),
                .a       (a),
                .b       (b),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_Z] = (mul_product[MSB:0] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            result_reg    <= '0;
            flags_reg     <= '0;
            carry_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            ready_en_reg  <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            case (state_reg)
                ST_BUSY: begin
                    if (mul_done) begin
                        state_reg     <= ST_HOLD;
                        out_valid_reg <= 1'b1;
                        result_reg    <= mul_product[MSB:0];
                        flags_reg     <= mul_flags;
                    end
                end
                default: begin
                    // IDLE and HOLD both accept; HOLD only when the result is being taken.
                    if (accept) begin
                        if (is_mul) begin
                            state_reg     <= ST_BUSY;
                            out_valid_reg <= 1'b0;
                        end else begin
                            state_reg     <= ST_HOLD;
                            out_valid_reg <= 1'b1;
                            result_reg    <= res_comb;
                            flags_reg     <= flg_comb;
                            if (carry_we) begin
                                carry_reg <= flg_comb[FLAG_C];
                            end
                        end
                    end else if ((state_reg == ST_HOLD) && out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: one task per scenario, inline comparisons.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'h0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [4:0]  flags;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(16), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Vector table for single-cycle ops: op, a, b, expected result, expected flags {Z,C,F,L,N}.
    localparam int NV = 14;
    logic [3:0]  v_op  [NV] = '{OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_LSH, OP_RSH,
                                OP_RSH, OP_ARSH, OP_ARSH, OP_SUB, OP_SUB, OP_SUB, OP_ADD};
    logic [15:0] v_a   [NV] = '{16'hF0F0, 16'hF0F0, 16'hAAAA, 16'h00FF, 16'h0001, 16'h0001, 16'h8000,
                                16'hFFFF, 16'h8000, 16'h8000, 16'h8000, 16'h0005, 16'h0001, 16'hFFFF};
    logic [15:0] v_b   [NV] = '{16'h0F0F, 16'h0F0F, 16'hAAAA, 16'h1234, 16'h000F, 16'h0010, 16'h0004,
                                16'h0011, 16'h0014, 16'h0004, 16'h0001, 16'h0005, 16'h0002, 16'hFFFF};
    logic [15:0] v_res [NV] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFF00, 16'h8000, 16'h0000, 16'h0800,
                                16'h0000, 16'hFFFF, 16'hF800, 16'h7FFF, 16'h0000, 16'hFFFF, 16'hFFFE};
    logic [4:0]  v_flg [NV] = '{5'b10000, 5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                                5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b10000, 5'b00000, 5'b00000};

    // Offer one op at the falling edge, let it be taken on the rising edge, then scramble operands.
    task automatic drive_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (result !== 16'h0 || flags !== 5'h0) begin
            errors++; $display("FAIL reset_result: got %h/%b expected 0000/00000", result, flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready: got %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL first_edge_in_ready: got %b expected 1", in_ready); end
        $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_add();
        drive_op(OP_ADD, 16'h7FFF, 16'h0001);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: got out_valid %b expected 1", out_valid); end
        checks++;
        if (result !== 16'h8000 || flags !== 5'b00100) begin
            errors++; $display("FAIL add_ovf: got %h/%b expected 8000/00100", result, flags);
        end
        $display("ADD 7fff+0001 -> %h flags %b", result, flags);
    endtask

    task automatic test_carry_chain();
        drive_op(OP_ADDU, 16'hFFFF, 16'h0001);
        checks++;
        if (result !== 16'h0000 || flags !== 5'b11000) begin
            errors++; $display("FAIL addu_carry: got %h/%b expected 0000/11000", result, flags);
        end
        $display("ADDU ffff+0001 -> %h flags %b", result, flags);
        drive_op(OP_ADDCU, 16'h0000, 16'h0000);
        checks++;
        if (result !== 16'h0001 || flags !== 5'b00000) begin
            errors++; $display("FAIL addcu_chain: got %h/%b expected 0001/00000", result, flags);
        end
        $display("ADDCU 0+0+c -> %h flags %b", result, flags);
        drive_op(OP_ADDC, 16'h0000, 16'h0000);
        checks++;
        if (result !== 16'h0000 || flags !== 5'b10000) begin
            errors++; $display("FAIL addc_cleared: got %h/%b expected 0000/10000", result, flags);
        end
        $display("ADDC 0+0+c -> %h flags %b", result, flags);
    endtask

    task automatic test_cmp();
        drive_op(OP_CMP, 16'hFFFF, 16'h0001);
        checks++;
        if (result !== 16'h0000 || flags !== 5'b00011) begin
            errors++; $display("FAIL cmp_signed: got %h/%b expected 0000/00011", result, flags);
        end
        $display("CMP ffff,0001 -> flags %b", flags);
        drive_op(OP_CMPU, 16'hFFFF, 16'h0001);
        checks++;
        if (result !== 16'h0000 || flags !== 5'b00000) begin
            errors++; $display("FAIL cmpu: got %h/%b expected 0000/00000", result, flags);
        end
        $display("CMPU ffff,0001 -> flags %b", flags);
        drive_op(OP_CMP, 16'h0005, 16'h0005);
        checks++;
        if (result !== 16'h0000 || flags !== 5'b10000) begin
            errors++; $display("FAIL cmp_equal: got %h/%b expected 0000/10000", result, flags);
        end
        $display("CMP 0005,0005 -> flags %b", flags);
    endtask

    task automatic test_logic_shift();
        for (int i = 0; i < NV; i++) begin
            drive_op(v_op[i], v_a[i], v_b[i]);
            checks++;
            if (out_valid !== 1'b1 || result !== v_res[i] || flags !== v_flg[i]) begin
                errors++;
                $display("FAIL vec%0d op%0h: got v=%b %h/%b expected v=1 %h/%b",
                         i, v_op[i], out_valid, result, flags, v_res[i], v_flg[i]);
            end
            $display("op %h a=%h b=%h -> %h flags %b", v_op[i], v_a[i], v_b[i], result, flags);
        end
    endtask

    task automatic test_illegal();
        drive_op(OP_ADDU, 16'hFFFF, 16'h0002);
        checks++;
        if (result !== 16'h0001 || flags !== 5'b01000) begin
            errors++; $display("FAIL addu_set_carry: got %h/%b expected 0001/01000", result, flags);
        end
        drive_op(4'hF, 16'h1234, 16'h5678);
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0000 || flags !== 5'b00000) begin
            errors++; $display("FAIL illegal_op: got v=%b %h/%b expected v=1 0000/00000", out_valid, result, flags);
        end
        $display("ILLEGAL -> %h flags %b", result, flags);
        drive_op(OP_ADDC, 16'h0000, 16'h0000);
        checks++;
        if (result !== 16'h0001 || flags !== 5'b00000) begin
            errors++; $display("FAIL carry_retained: got %h/%b expected 0001/00000", result, flags);
        end
        $display("ADDC after illegal -> %h flags %b", result, flags);
    endtask

    task automatic test_mul();
        drive_op(OP_MUL, 16'd300, 16'd300);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++; $display("FAIL mul_busy_c%0d: got v=%b r=%b expected v=0 r=0", c, out_valid, in_ready);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h5F90 || flags !== 5'b01000) begin
            errors++; $display("FAIL mul_300x300: got v=%b %h/%b expected v=1 5f90/01000", out_valid, result, flags);
        end
        $display("MUL 300*300 -> %h flags %b", result, flags);
        drive_op(OP_MUL, 16'h0100, 16'h0100);
        repeat (16) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0000 || flags !== 5'b11000) begin
            errors++; $display("FAIL mul_zero_low: got v=%b %h/%b expected v=1 0000/11000", out_valid, result, flags);
        end
        $display("MUL 0100*0100 -> %h flags %b", result, flags);
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive_op(OP_XOR, 16'hF0F0, 16'h0FF0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'hFF00 || flags !== 5'b00000) begin
                errors++;
                $display("FAIL hold_c%0d: got v=%b r=%b %h/%b expected v=1 r=0 ff00/00000",
                         c, out_valid, in_ready, result, flags);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        op = OP_AND;
        a = 16'hFF00;
        b = 16'h0F0F;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0F00 || flags !== 5'b00000) begin
            errors++; $display("FAIL no_bubble: got v=%b %h/%b expected v=1 0f00/00000", out_valid, result, flags);
        end
        $display("back-pressure release AND -> %h flags %b", result, flags);
    endtask

    task automatic test_reset_mid_mul();
        drive_op(OP_ADDU, 16'hFFFF, 16'h0002);
        drive_op(OP_MUL, 16'd300, 16'd300);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 16'h0 || flags !== 5'h0) begin
            errors++;
            $display("FAIL reset_mid_mul: got v=%b r=%b %h/%b expected v=0 r=0 0000/00000",
                     out_valid, in_ready, result, flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL lost_mul_c%0d: got v=%b expected 0", c, out_valid); end
        end
        drive_op(OP_ADDC, 16'h0000, 16'h0000);
        checks++;
        if (result !== 16'h0000 || flags !== 5'b10000) begin
            errors++; $display("FAIL carry_reset: got %h/%b expected 0000/10000", result, flags);
        end
        $display("ADDC after reset -> %h flags %b", result, flags);
        drive_op(OP_ARSH, 16'h8000, 16'd20);
        checks++;
        if (result !== 16'hFFFF || flags !== 5'b00000) begin
            errors++; $display("FAIL arsh_big: got %h/%b expected ffff/00000", result, flags);
        end
        $display("ARSH 8000>>>20 -> %h flags %b", result, flags);
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_cmp();
        test_logic_shift();
        test_illegal();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width, any value >= 4.
REQ-002 Parameter MUL_EN, default 1: 1 = MUL supported; 0 = MUL treated as an illegal op.
REQ-003 clk  in  1  rising-edge clock, the only clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  operation offered this cycle.
REQ-006 in_ready  out  1  block can accept an operation this cycle.
REQ-007 op  in  4  operation code (alu_op_t).
REQ-008 a, b  in  WIDTH each  operands.
REQ-009 out_valid  out  1  result and flags valid.
REQ-010 out_ready  in  1  consumer takes the result this cycle.
REQ-011 result  out  WIDTH  registered result.
REQ-012 flags  out  5  registered flags: [0] N, [1] L, [2] F (signed overflow), [3] C, [4] Z.

Function
REQ-013 Accept when in_valid && in_ready; drop result when out_valid && out_ready.
REQ-014 FSM states:
- IDLE: in_ready=1, out_valid=0.
- BUSY: MUL iterating; in_ready=0, out_valid=0.
- HOLD: out_valid=1; in_ready=out_ready.
REQ-015 Transitions:
- Accept of a single-cycle op -> HOLD next cycle (latency 1).
- Accept of MUL -> BUSY; after WIDTH cycles -> HOLD (latency WIDTH+1).
- HOLD, out_ready, no accept -> IDLE.
- HOLD, out_ready, accept -> HOLD or BUSY, with no bubble.
- HOLD, out_ready=0 -> result and flags held stable.
REQ-016 ADD/SUB: modulo 2^WIDTH. F = signed overflow. C=0.
REQ-017 ADDU: C = carry out of the WIDTH-bit sum. F=0.
REQ-018 ADDC/ADDCU: add the stored carry bit; ADDCU updates C, ADDC updates F.
REQ-019 Stored carry bit:
- Internal register, written with C by ADDU and ADDCU only.
- Retained across all other ops.
REQ-020 CMP/CMPU: result=0.
- a<b (signed for CMP, unsigned for CMPU) -> N=L=1.
- a==b -> Z=1.
- All other flags 0.
REQ-021 AND/OR/XOR/NOT(a): Z set on zero result; other flags 0.
REQ-022 LSH/RSH/ARSH: shift a by unsigned b.
- b >= WIDTH -> 0, or all sign bits for ARSH.
- Flags 0.
REQ-023 MUL: iterative shift-add, one partial product per BUSY cycle.
- result = low WIDTH bits of a*b (unsigned).
- C = OR of the discarded high bits. Z set on zero result.
REQ-024 Z is set for ADD/ADDU/ADDC/ADDCU/SUB/logic/MUL when result==0; flags not listed for an op are 0.
REQ-025 Illegal or unused op: accepted with latency 1; result=0, flags=0; stored carry unchanged.
REQ-026 Operands are captured at accept; input changes during BUSY/HOLD have no effect.

Reset
REQ-027 rst_n low, at any time including mid-MUL or HOLD:
- State -> IDLE.
- result=0, flags=0, stored carry=0, out_valid=0.
- Any in-flight op is lost.
REQ-028 in_ready is 0 while rst_n is low; it is 1 from the first clk edge after release.

Structure
REQ-029 Package alu_pkg holds alu_op_t, flag bit index constants, and the state enum.
REQ-030 Sub-module alu_mul_iter implements the MUL datapath (start, done, product).
- Instantiated only when MUL_EN=1.
- All other ops are combinational inside alu_seq, registered at HOLD entry.

Verification
REQ-031 ADD, a=16'h7FFF, b=16'h0001 -> result 16'h8000, F=1, Z=0, 1 cycle after accept.
REQ-032 Carry chain:
- ADDU a=16'hFFFF, b=16'h0001 -> result 0, C=1, Z=1.
- Then ADDCU a=0, b=0 -> result 16'h0001, C=0.
REQ-033 MUL, a=16'd300, b=16'd300:
- BUSY for 16 cycles, out_valid on cycle 17.
- result 16'h5F90, C=1.
REQ-034 Back-pressure:
- out_ready held 0 for 5 cycles in HOLD -> result and flags stable, in_ready=0.
- Then out_ready=1 with in_valid=1 -> next op accepted the same cycle.
REQ-035 CMP, a=16'hFFFF, b=16'h0001 -> N=L=1. CMPU with the same operands -> flags 0.
REQ-036 Reset and shifts:
- rst_n low during MUL cycle 8 -> out_valid=0 and stored carry=0 immediately; the next ADDC of 0+0 gives 0.
- ARSH a=16'h8000, b=20 -> 16'hFFFF.
